// File: rtl/bram_tdp_pipe.sv
// rtl/bram_tdp_pipe.sv - true-dual-port BRAM with clear engine, per-port rvalid and collision handling
// Optional BRAM_TDP_COLLISION_FWD_EN: a same-address reader gets the merged write word instead of a poison word.
module bram_tdp_pipe #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 6,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    READ_LATENCY   = 1,
  parameter string                 WRITE_MODE     = "write_first",
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  localparam int                   NUM_LANES      = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clear_req,
  output logic                  ready,
  input  logic                  en_1,
  input  logic [NUM_LANES-1:0]  write_en_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  rvalid_1,
  input  logic                  en_2,
  input  logic [NUM_LANES-1:0]  write_en_2,
  input  logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  output logic [DATA_WIDTH-1:0] data_out_2,
  output logic                  rvalid_2,
  output logic                  collision
);

  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

`ifndef BRAM_TDP_COLLISION_FWD_EN
  function automatic logic [DATA_WIDTH-1:0] poison_word();
    logic [31:0]           pat;
    logic [DATA_WIDTH-1:0] w;
    pat = 32'hDEADBEEF;
    for (int i = 0; i < DATA_WIDTH; i++) w[i] = pat[i % 32];
    return w;
  endfunction

  localparam logic [DATA_WIDTH-1:0] POISON = poison_word();
`endif

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  clearing;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      S_CLEAR: begin
        clr_cnt_nxt = clr_cnt + ADDR_ONE;
        if (clr_cnt == ADDR_MAX) begin
          state_nxt   = S_READY;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        if (clear_req) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
    endcase
  end

  always_comb begin
    ready    = (state == S_READY);
    clearing = (state == S_CLEAR);
  end

  // Effective write lanes are zero for any request not accepted.
  logic                  acc_1, acc_2, wr_1, wr_2, same_addr;
  logic [NUM_LANES-1:0]  lane_1, lane_2;
  logic [DATA_WIDTH-1:0] rd_old_1, rd_old_2, merged_1, merged_2;

  always_comb begin
    acc_1     = en_1 && ready;
    acc_2     = en_2 && ready;
    lane_1    = acc_1 ? write_en_1 : '0;
    lane_2    = acc_2 ? write_en_2 : '0;
    wr_1      = |lane_1;
    wr_2      = |lane_2;
    same_addr = (addr_1 == addr_2);
    rd_old_1  = mem[addr_1];
    rd_old_2  = mem[addr_2];
  end

  // Word each address will hold after this edge, port 1 winning shared lanes.
  always_comb begin
    merged_1 = rd_old_1;
    merged_2 = rd_old_2;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_1[i])
        merged_1[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in_1[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (same_addr && lane_2[i])
        merged_1[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in_2[i*BYTE_WIDTH +: BYTE_WIDTH];
      if (same_addr && lane_1[i])
        merged_2[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in_1[i*BYTE_WIDTH +: BYTE_WIDTH];
      else if (lane_2[i])
        merged_2[i*BYTE_WIDTH +: BYTE_WIDTH] = data_in_2[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (clearing && resetn) begin
      mem[clr_cnt] <= INIT_VALUE;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (lane_2[i])
          mem[addr_2][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in_2[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (lane_1[i])
          mem[addr_1][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_in_1[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic                  res_valid_1, res_valid_2;
  logic [DATA_WIDTH-1:0] res_data_1, res_data_2;

  always_comb begin
    res_valid_1 = 1'b0;
    res_data_1  = rd_old_1;
    if (acc_1) begin
      if (wr_1) begin
        if (WRITE_MODE == "write_first") begin
          res_valid_1 = 1'b1;
          res_data_1  = merged_1;
        end else if (WRITE_MODE == "read_first") begin
          res_valid_1 = 1'b1;
        end
      end else begin
        res_valid_1 = 1'b1;
        if (wr_2 && same_addr) begin
`ifdef BRAM_TDP_COLLISION_FWD_EN
          res_data_1 = merged_1;
`else
          res_data_1 = POISON;
`endif
        end
      end
    end
  end

  always_comb begin
    res_valid_2 = 1'b0;
    res_data_2  = rd_old_2;
    if (acc_2) begin
      if (wr_2) begin
        if (WRITE_MODE == "write_first") begin
          res_valid_2 = 1'b1;
          res_data_2  = merged_2;
        end else if (WRITE_MODE == "read_first") begin
          res_valid_2 = 1'b1;
        end
      end else begin
        res_valid_2 = 1'b1;
        if (wr_1 && same_addr) begin
`ifdef BRAM_TDP_COLLISION_FWD_EN
          res_data_2 = merged_2;
`else
          res_data_2 = POISON;
`endif
        end
      end
    end
  end

  logic                  out_valid_1, out_valid_2;
  logic [DATA_WIDTH-1:0] out_data_1, out_data_2;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s_valid_1, s_valid_2;
      logic [DATA_WIDTH-1:0] s_data_1, s_data_2;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s_valid_1 <= 1'b0;
          s_valid_2 <= 1'b0;
          s_data_1  <= '0;
          s_data_2  <= '0;
        end else begin
          s_valid_1 <= res_valid_1;
          s_valid_2 <= res_valid_2;
          if (res_valid_1) s_data_1 <= res_data_1;
          if (res_valid_2) s_data_2 <= res_data_2;
        end
      end

      assign out_valid_1 = s_valid_1;
      assign out_valid_2 = s_valid_2;
      assign out_data_1  = s_data_1;
      assign out_data_2  = s_data_2;
    end else begin : g_lat1
      assign out_valid_1 = res_valid_1;
      assign out_valid_2 = res_valid_2;
      assign out_data_1  = res_data_1;
      assign out_data_2  = res_data_2;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_1   <= 1'b0;
      rvalid_2   <= 1'b0;
      data_out_1 <= RESET_VALUE;
      data_out_2 <= RESET_VALUE;
      collision  <= 1'b0;
    end else begin
      rvalid_1  <= out_valid_1;
      rvalid_2  <= out_valid_2;
      if (out_valid_1) data_out_1 <= out_data_1;
      if (out_valid_2) data_out_2 <= out_data_2;
      collision <= same_addr && |(lane_1 & lane_2);
    end
  end

endmodule

// File: tb/tb_bram_tdp_pipe.sv
// tb/tb_bram_tdp_pipe.sv - directed bench for bram_tdp_pipe at read latency 1 and 2
module tb_bram_tdp_pipe;

  logic        clk = 1'b0;
  logic        resetn;
  logic        clear_req;
  logic        en_1, en_2;
  logic [3:0]  write_en_1, write_en_2;
  logic [5:0]  addr_1, addr_2;
  logic [31:0] data_in_1, data_in_2;

  logic [31:0] a_do1, a_do2, b_do1, b_do2;
  logic        a_rv1, a_rv2, a_col, a_rdy;
  logic        b_rv1, b_rv2, b_col, b_rdy;

  int errors = 0;
  int checks = 0;

`ifdef BRAM_TDP_COLLISION_FWD_EN
  localparam logic [31:0] RW_EXP = 32'hCAFE0001;
`else
  localparam logic [31:0] RW_EXP = 32'hDEADBEEF;
`endif

  always #5 clk = ~clk;

  bram_tdp_pipe #(.READ_LATENCY(1), .INIT_VALUE(32'hA5A5A5A5), .CLEAR_ON_RESET(1'b1)) u_lat1 (
    .clk(clk), .resetn(resetn), .clear_req(clear_req), .ready(a_rdy),
    .en_1(en_1), .write_en_1(write_en_1), .addr_1(addr_1), .data_in_1(data_in_1),
    .data_out_1(a_do1), .rvalid_1(a_rv1),
    .en_2(en_2), .write_en_2(write_en_2), .addr_2(addr_2), .data_in_2(data_in_2),
    .data_out_2(a_do2), .rvalid_2(a_rv2), .collision(a_col)
  );

  bram_tdp_pipe #(.READ_LATENCY(2), .INIT_VALUE(32'hA5A5A5A5), .CLEAR_ON_RESET(1'b1)) u_lat2 (
    .clk(clk), .resetn(resetn), .clear_req(clear_req), .ready(b_rdy),
    .en_1(en_1), .write_en_1(write_en_1), .addr_1(addr_1), .data_in_1(data_in_1),
    .data_out_1(b_do1), .rvalid_1(b_rv1),
    .en_2(en_2), .write_en_2(write_en_2), .addr_2(addr_2), .data_in_2(data_in_2),
    .data_out_2(b_do2), .rvalid_2(b_rv2), .collision(b_col)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e1, input logic [3:0] w1, input logic [5:0] a1, input logic [31:0] d1,
                       input logic e2, input logic [3:0] w2, input logic [5:0] a2, input logic [31:0] d2);
    en_1 = e1; write_en_1 = w1; addr_1 = a1; data_in_1 = d1;
    en_2 = e2; write_en_2 = w2; addr_2 = a2; data_in_2 = d2;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad_rv;
    resetn = 1'b0;
    clear_req = 1'b0;
    idle();
    tick();
    tick();
    check("rst_data_out_1", a_do1, 32'h0);
    check("rst_rvalid_1", {31'b0, a_rv1}, 32'h0);
    check("rst_collision", {31'b0, a_col}, 32'h0);
    check("rst_ready", {31'b0, a_rdy}, 32'h0);
    check("rst_ready_lat2", {31'b0, b_rdy}, 32'h0);

    // Initial clear: ready must stay low for exactly DEPTH edges.
    resetn = 1'b1;
    n = 0;
    while (!a_rdy && n < 200) begin
      tick();
      n++;
    end
    check("clear_cycles", n, 64);
    check("clear_ready_lat2", {31'b0, b_rdy}, 32'h1);

    drive(1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd63, 32'h0);
    tick();
    idle();
    check("init_addr0", a_do1, 32'hA5A5A5A5);
    check("init_addr63", a_do2, 32'hA5A5A5A5);
    check("init_rvalid_1", {31'b0, a_rv1}, 32'h1);
    check("lat2_not_yet", {31'b0, b_rv1}, 32'h0);
    tick();
    check("rvalid_pulse", {31'b0, a_rv1}, 32'h0);
    check("lat2_rvalid", {31'b0, b_rv1}, 32'h1);
    check("lat2_addr0", b_do1, 32'hA5A5A5A5);
    check("lat2_addr63", b_do2, 32'hA5A5A5A5);

    // Byte-lane write over a zero word.
    drive(1'b1, 4'hF, 6'd5, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    drive(1'b1, 4'b0101, 6'd5, 32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    check("wf_merged", a_do1, 32'h00220044);
    drive(1'b1, 4'h0, 6'd5, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    idle();
    check("lane_read", a_do1, 32'h00220044);
    check("lane_rvalid", {31'b0, a_rv1}, 32'h1);
    tick();
    check("lane_read_lat2", b_do1, 32'h00220044);
    check("lane_rvalid_lat2", {31'b0, b_rv1}, 32'h1);

    // Write/write collision on shared lane 1.
    drive(1'b1, 4'b0011, 6'd9, 32'hAAAAAAAA, 1'b1, 4'b1110, 6'd9, 32'hBBBBBBBB);
    tick();
    idle();
    check("ww_collision", {31'b0, a_col}, 32'h1);
    check("ww_wf_port1", a_do1, 32'hBBBBAAAA);
    check("ww_wf_port2", a_do2, 32'hBBBBAAAA);
    tick();
    check("ww_collision_pulse", {31'b0, a_col}, 32'h0);
    drive(1'b1, 4'h0, 6'd9, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    idle();
    check("ww_stored", a_do1, 32'hBBBBAAAA);

    // Read/write collision.
    drive(1'b1, 4'hF, 6'd3, 32'hCAFE0001, 1'b1, 4'h0, 6'd3, 32'h0);
    tick();
    idle();
    check("rw_data", a_do2, RW_EXP);
    check("rw_rvalid", {31'b0, a_rv2}, 32'h1);
    tick();
    check("rw_data_lat2", b_do2, RW_EXP);
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'd3, 32'h0);
    tick();
    idle();
    check("rw_stored", a_do2, 32'hCAFE0001);
    tick();

    // Back-to-back reads on port 2.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'hF, 6'(10 + i), 32'h1000 + i, 1'b0, 4'h0, 6'd0, 32'h0);
      tick();
    end
    idle();
    tick();
    tick();
    for (int c = 0; c < 13; c++) begin
      if (c < 10) drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'(10 + c), 32'h0);
      else idle();
      tick();
      check("b2b_rvalid_lat1", {31'b0, a_rv2}, (c <= 9) ? 32'h1 : 32'h0);
      check("b2b_rvalid_lat2", {31'b0, b_rv2}, (c >= 1 && c <= 10) ? 32'h1 : 32'h0);
      if (c <= 9) check("b2b_data_lat1", a_do2, 32'h1000 + c);
      if (c >= 1 && c <= 10) check("b2b_data_lat2", b_do2, 32'h1000 + c - 1);
    end

    // Re-clear during traffic, then reset mid-clear.
    clear_req = 1'b1;
    drive(1'b1, 4'h0, 6'd9, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
    tick();
    clear_req = 1'b0;
    check("clr_ready_low", {31'b0, a_rdy}, 32'h0);
    check("clr_last_read", a_do1, 32'hBBBBAAAA);
    bad_rv = 0;
    drive(1'b1, 4'hF, 6'd7, 32'h77777777, 1'b1, 4'h0, 6'd7, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_rv1 || a_rv2 || a_rdy) bad_rv++;
    end
    check("clr_ignored", bad_rv, 0);
    resetn = 1'b0;
    #2;
    check("mid_rst_data_out_1", a_do1, 32'h0);
    check("mid_rst_data_out_2_lat2", b_do2, 32'h0);
    check("mid_rst_rvalid_lat2", {31'b0, b_rv1}, 32'h0);
    check("mid_rst_ready", {31'b0, a_rdy}, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    n = 0;
    bad_rv = 0;
    while (!a_rdy && n < 200) begin
      tick();
      n++;
      if (a_rv1 || a_rv2 || b_rv1 || b_rv2) bad_rv++;
    end
    idle();
    check("reclear_cycles", n, 64);
    check("reclear_en_ignored", bad_rv, 0);
    drive(1'b1, 4'h0, 6'd7, 32'h0, 1'b1, 4'h0, 6'd5, 32'h0);
    tick();
    idle();
    check("reclear_addr7", a_do1, 32'hA5A5A5A5);
    check("reclear_addr5", a_do2, 32'hA5A5A5A5);
    tick();
    check("reclear_addr7_lat2", b_do1, 32'hA5A5A5A5);
    check("reclear_addr5_lat2", b_do2, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
